// File: rtl/grid_scanner.sv
// Grid cell sequencer: walks an address range and emits addr/col/row/pixel origin per cell.
// Latency: first cell valid the cycle after start; one cell per cycle while cell_ready is high; stalls hold outputs.
module grid_scanner #(
    parameter int COLS     = 16,
    parameter int ROWS     = 16,
    parameter int ADDR_W   = 9,
    parameter int POS_W    = 4,
    parameter int PIX_W    = 11,
    parameter int CELL_W   = 20,
    parameter int SPACING  = 5,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    input  logic              cell_ready,
    output logic              cell_valid,
    output logic [ADDR_W-1:0] cell_addr,
    output logic [POS_W-1:0]  cell_col,
    output logic [POS_W-1:0]  cell_row,
    output logic [PIX_W-1:0]  pix_x,
    output logic [PIX_W-1:0]  pix_y,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status
);

    localparam int N    = COLS * ROWS;
    localparam int STEP = CELL_W + SPACING;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, r_last;
    logic [POS_W-1:0]    r_col, r_row;
    logic [PIX_W-1:0]    r_pix_x, r_pix_y;
    logic [1:0]          r_status;

    logic [ADDR_W-1:0]   w_first, w_last;
    logic                w_range_ok, w_xfer, w_at_last;
    logic [POS_W-1:0]    w_col0, w_row0;
    logic [PIX_W-1:0]    w_px0, w_py0;

    assign w_first    = mode ? first_addr : '0;
    assign w_last     = mode ? last_addr  : ADDR_W'(N - 1);
    assign w_range_ok = (w_first <= w_last) && (int'(w_last) < N);
    assign w_xfer     = (r_state == S_SCAN) && cell_ready;
    assign w_at_last  = (r_addr == r_last);

    // Start position from a constant row-boundary table: no divider needed.
    always_comb begin
        w_row0 = '0;
        w_col0 = '0;
        w_py0  = PIX_W'(ORIGIN_Y);
        w_px0  = PIX_W'(ORIGIN_X);
        for (int r = 0; r < ROWS; r++) begin
            if (int'(w_first) >= r * COLS) begin
                w_row0 = POS_W'(r);
                w_col0 = POS_W'(int'(w_first) - r * COLS);
                w_py0  = PIX_W'(ORIGIN_Y + r * STEP);
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (w_col0 == POS_W'(c)) begin
                w_px0 = PIX_W'(ORIGIN_X + c * STEP);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = w_range_ok ? S_SCAN : S_DONE;
            S_SCAN:  if ((w_xfer && w_at_last) || abort) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr   <= '0;
            r_last   <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_pix_x  <= '0;
            r_pix_y  <= '0;
            r_status <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_range_ok) begin
                        r_addr  <= w_first;
                        r_last  <= w_last;
                        r_col   <= w_col0;
                        r_row   <= w_row0;
                        r_pix_x <= w_px0;
                        r_pix_y <= w_py0;
                    end else if (start) begin
                        r_status <= 2'b10;
                    end
                end
                S_SCAN: begin
                    // Outputs freeze on the last cell so row never steps past the grid.
                    if (w_xfer && !w_at_last) begin
                        r_addr <= r_addr + 1'b1;
                        if (r_col == POS_W'(COLS - 1)) begin
                            r_col   <= '0;
                            r_row   <= r_row + 1'b1;
                            r_pix_x <= PIX_W'(ORIGIN_X);
                            r_pix_y <= r_pix_y + PIX_W'(STEP);
                        end else begin
                            r_col   <= r_col + 1'b1;
                            r_pix_x <= r_pix_x + PIX_W'(STEP);
                        end
                    end
                    if (w_xfer && w_at_last) begin
                        r_status <= 2'b00;
                    end else if (abort) begin
                        r_status <= 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cell_valid = (r_state == S_SCAN);
    assign busy       = (r_state == S_SCAN);
    assign done       = (r_state == S_DONE);
    assign cell_addr  = r_addr;
    assign cell_col   = r_col;
    assign cell_row   = r_row;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign status     = r_status;

endmodule
